// File: rtl/mem_dados_arb_pkg.sv
// mem_dados_arb_pkg: shared types for the two-port data-memory arbiter.
// Holds the FSM state enum, requester ids (A=0, B=1) and default widths.
package mem_dados_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      RESP  = 2'd2
   } arb_state_e;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_e;

endpackage

// File: rtl/mem_dados_arb_rr_arb2.sv
// rr_arb2: combinational two-way round-robin winner select.
// Ports: req_a/req_b requests, last_gnt previous owner -> win.
module rr_arb2
   import mem_dados_arb_pkg::*;
(
   input  logic    req_a,
   input  logic    req_b,
   input  req_id_e last_gnt,
   output req_id_e win
);

   always_comb begin
      win = REQ_A;
      if (req_a && req_b) begin
         win = (last_gnt == REQ_A) ? REQ_B : REQ_A;
      end else if (req_b) begin
         win = REQ_B;
      end
   end

endmodule

// File: rtl/mem_dados_arb.sv
// mem_dados_arb: IDLE->SERVE->RESP arbiter giving requesters A/B a data memory.
// Ports: clock, reset_n (sync, low), req/we/addr/wdata per side, gnt/ack, rdata,
// MemWrite/MemRead/endereco/dado_in/dado_out memory side.
// Optional MEM_ARB_LOCK_EN adds lock_a/lock_b to keep ownership across accesses.
module mem_dados_arb
   import mem_dados_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
`ifdef MEM_ARB_LOCK_EN
   input  logic              lock_a,
   input  logic              lock_b,
`endif
   input  logic              req_a,
   input  logic              req_b,
   input  logic              we_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wdata_a,
   input  logic [DATA_W-1:0] wdata_b,
   output logic              gnt_a,
   output logic              gnt_b,
   output logic              ack_a,
   output logic              ack_b,
   output logic [DATA_W-1:0] rdata,
   output logic              MemWrite,
   output logic              MemRead,
   output logic [ADDR_W-1:0] endereco,
   output logic [DATA_W-1:0] dado_in,
   input  logic [DATA_W-1:0] dado_out
);

   arb_state_e        state_q, state_d;
   req_id_e           win_q, win_d;
   req_id_e           last_q, last_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   req_id_e           rr_win;
   req_id_e           sel;

   rr_arb2 u_rr (
      .req_a    (req_a),
      .req_b    (req_b),
      .last_gnt (last_q),
      .win      (rr_win)
   );

`ifdef MEM_ARB_LOCK_EN
   logic lock_a_q, lock_a_d;
   logic lock_b_q, lock_b_d;

   // A lock taken in RESP overrides round-robin for the next IDLE only.
   always_comb begin
      sel = rr_win;
      if (lock_a_q && req_a && !(lock_b_q && req_b)) begin
         sel = REQ_A;
      end else if (lock_b_q && req_b && !(lock_a_q && req_a)) begin
         sel = REQ_B;
      end
   end
`else
   always_comb begin
      sel = rr_win;
   end
`endif

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      last_d  = last_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifdef MEM_ARB_LOCK_EN
      lock_a_d = lock_a_q;
      lock_b_d = lock_b_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (req_a || req_b) begin
               state_d = SERVE;
               win_d   = sel;
               last_d  = sel;
               we_d    = (sel == REQ_A) ? we_a    : we_b;
               addr_d  = (sel == REQ_A) ? addr_a  : addr_b;
               wdata_d = (sel == REQ_A) ? wdata_a : wdata_b;
`ifdef MEM_ARB_LOCK_EN
               lock_a_d = 1'b0;
               lock_b_d = 1'b0;
`endif
            end
         end
         SERVE: begin
            state_d = RESP;
            if (!we_q) begin
               rdata_d = dado_out;
            end
         end
         RESP: begin
            state_d = IDLE;
`ifdef MEM_ARB_LOCK_EN
            lock_a_d = lock_a;
            lock_b_d = lock_b;
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         win_q   <= REQ_A;
         last_q  <= REQ_B;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

`ifdef MEM_ARB_LOCK_EN
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         lock_a_q <= 1'b0;
         lock_b_q <= 1'b0;
      end else begin
         lock_a_q <= lock_a_d;
         lock_b_q <= lock_b_d;
      end
   end
`endif

   assign gnt_a = (state_q != IDLE) && (win_q == REQ_A);
   assign gnt_b = (state_q != IDLE) && (win_q == REQ_B);
   assign ack_a = (state_q == RESP) && (win_q == REQ_A);
   assign ack_b = (state_q == RESP) && (win_q == REQ_B);

   // Gating with reset_n kills the write on an edge where reset is sampled.
   assign MemWrite = (state_q == SERVE) && we_q && reset_n;
   assign MemRead  = (state_q == SERVE) && !we_q && reset_n;

   assign endereco = addr_q;
   assign dado_in  = wdata_q;
   assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_dados_arb.sv
// tb_mem_dados_arb: arbiter paired with a Mem_Dados-style memory model,
// directed scenarios plus randomized traffic against a reference model.
module tb_mem_dados_arb;

   logic       clock;
   logic       reset_n;
   logic       req_a, req_b, we_a, we_b;
   logic [7:0] addr_a, addr_b, wdata_a, wdata_b;
   logic       gnt_a, gnt_b, ack_a, ack_b;
   logic [7:0] rdata;
   logic       MemWrite, MemRead;
   logic [7:0] endereco, dado_in, dado_out;
`ifdef MEM_ARB_LOCK_EN
   logic       lock_a, lock_b;
`endif

   int errs;
   int checks;

   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   logic       mem_clear;
   bit         last_b;

   mem_dados_arb #(.ADDR_W(8), .DATA_W(8)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
`ifdef MEM_ARB_LOCK_EN
      .lock_a   (lock_a),
      .lock_b   (lock_b),
`endif
      .req_a    (req_a),
      .req_b    (req_b),
      .we_a     (we_a),
      .we_b     (we_b),
      .addr_a   (addr_a),
      .addr_b   (addr_b),
      .wdata_a  (wdata_a),
      .wdata_b  (wdata_b),
      .gnt_a    (gnt_a),
      .gnt_b    (gnt_b),
      .ack_a    (ack_a),
      .ack_b    (ack_b),
      .rdata    (rdata),
      .MemWrite (MemWrite),
      .MemRead  (MemRead),
      .endereco (endereco),
      .dado_in  (dado_in),
      .dado_out (dado_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Mem_Dados: combinational read, write on rising edge.
   assign dado_out = mem[endereco];
   always @(posedge clock) begin
      if (mem_clear) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h3C;
      end else if (MemWrite) begin
         mem[endereco] <= dado_in;
      end
   end

   task automatic wait_ack(output int lat, output bit who,
                           output logic [7:0] rd, output logic [7:0] sa,
                           output logic [7:0] sd, output bit sw,
                           output bit sr, output bit perr);
      lat = -1; who = 0; rd = '0; sa = '0; sd = '0;
      sw = 0; sr = 0; perr = 0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clock);
         if ((gnt_a && gnt_b) || (ack_a && ack_b) || (MemWrite && MemRead))
            perr = 1;
         if ((MemWrite || MemRead) && !(gnt_a || gnt_b)) perr = 1;
         if (MemWrite || MemRead) begin
            sa = endereco; sd = dado_in; sw = MemWrite; sr = MemRead;
         end
         if (ack_a || ack_b) begin
            lat = n; who = ack_b; rd = rdata;
            break;
         end
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req_a = 0; req_b = 0;
`ifdef MEM_ARB_LOCK_EN
      lock_a = 0; lock_b = 0;
`endif
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      last_b = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; mem_clear = 1'b1;
      req_a = 0; req_b = 0; we_a = 0; we_b = 0;
      addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
`ifdef MEM_ARB_LOCK_EN
      lock_a = 0; lock_b = 0;
`endif
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h3C;
      repeat (2) @(negedge clock);
      mem_clear = 1'b0; reset_n = 1'b1; last_b = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         checks++;
         if ({gnt_a, gnt_b, ack_a, ack_b, MemWrite, MemRead,
              endereco, dado_in, rdata} !== 30'd0) begin
            errs++;
            $display("FAIL reset_idle c%0d: got %b want 0", c,
                     {gnt_a, gnt_b, ack_a, ack_b, MemWrite, MemRead,
                      endereco, dado_in, rdata});
         end
      end
   endtask

   task automatic test_write_read();
      int lat; bit who, sw, sr, pe; logic [7:0] rd, sa, sd;
      req_a = 1; we_a = 1; addr_a = 8'd10; wdata_a = 8'h02;
      wait_ack(lat, who, rd, sa, sd, sw, sr, pe);
      req_a = 0;
      checks++;
      if (lat !== 2 || who !== 1'b0) begin
         errs++; $display("FAIL wr_ack: got lat=%0d who=%0d want 2/A", lat, who);
      end
      checks++;
      if ({sw, sr, sa, sd} !== {2'b10, 8'd10, 8'h02}) begin
         errs++; $display("FAIL wr_strobe: got %b %b %h %h want 1 0 0a 02",
                          sw, sr, sa, sd);
      end
      ref_mem[10] = 8'h02; last_b = 0;
      @(negedge clock);
      checks++;
      if (mem[10] !== 8'h02) begin
         errs++; $display("FAIL wr_mem: got %h want 02", mem[10]);
      end
      req_b = 1; we_b = 0; addr_b = 8'd10;
      wait_ack(lat, who, rd, sa, sd, sw, sr, pe);
      req_b = 0;
      checks++;
      if (lat !== 2 || who !== 1'b1 || rd !== 8'h02 || sr !== 1'b1) begin
         errs++; $display("FAIL rd_b: got lat=%0d who=%0d rd=%h sr=%0d want 2/B/02/1",
                          lat, who, rd, sr);
      end
      last_b = 1;
      @(negedge clock);
   endtask

   task automatic test_tie();
      int lat; bit who, sw, sr, pe; logic [7:0] rd, sa, sd;
      bit exp;
      do_reset();
      req_a = 1; we_a = 0; addr_a = 8'd10;
      req_b = 1; we_b = 0; addr_b = 8'd15;
      for (int i = 0; i < 6; i++) begin
         exp = ~last_b;
         wait_ack(lat, who, rd, sa, sd, sw, sr, pe);
         checks++;
         if (who !== exp || lat !== ((i == 0) ? 2 : 3) || pe) begin
            errs++; $display("FAIL tie_%0d: got who=%0d lat=%0d perr=%0d want who=%0d",
                             i, who, lat, pe, exp);
         end
         checks++;
         if (rd !== ref_mem[exp ? 15 : 10]) begin
            errs++; $display("FAIL tie_rd_%0d: got %h want %h", i, rd,
                             ref_mem[exp ? 15 : 10]);
         end
         last_b = exp;
      end
      req_a = 0; req_b = 0;
      @(negedge clock);
   endtask

   task automatic test_addr_change();
      req_a = 1; we_a = 1; addr_a = 8'd10; wdata_a = 8'h77;
      @(negedge clock);
      addr_a = 8'd15; wdata_a = 8'h11;
      #1;
      checks++;
      if (gnt_a !== 1'b1 || endereco !== 8'd10 || dado_in !== 8'h77) begin
         errs++; $display("FAIL chg_serve: got gnt=%0d addr=%0d din=%h want 1/10/77",
                          gnt_a, endereco, dado_in);
      end
      @(negedge clock);
      checks++;
      if (ack_a !== 1'b1) begin
         errs++; $display("FAIL chg_ack: got %0d want 1", ack_a);
      end
      req_a = 0;
      ref_mem[10] = 8'h77; last_b = 0;
      @(negedge clock);
      checks++;
      if (mem[10] !== 8'h77 || mem[15] !== ref_mem[15]) begin
         errs++; $display("FAIL chg_mem: got %h/%h want 77/%h",
                          mem[10], mem[15], ref_mem[15]);
      end
   endtask

   task automatic test_reset_abort();
      req_a = 1; we_a = 1; addr_a = 8'd9; wdata_a = 8'hAA;
      @(negedge clock);
      checks++;
      if (gnt_a !== 1'b1 || MemWrite !== 1'b1) begin
         errs++; $display("FAIL abort_serve: got gnt=%0d mw=%0d want 1/1",
                          gnt_a, MemWrite);
      end
      reset_n = 0;
      #1;
      checks++;
      if (MemWrite !== 1'b0) begin
         errs++; $display("FAIL abort_mw: got %0d want 0", MemWrite);
      end
      @(negedge clock);
      checks++;
      if ({ack_a, ack_b, gnt_a, gnt_b} !== 4'b0) begin
         errs++; $display("FAIL abort_ack: got %b want 0000",
                          {ack_a, ack_b, gnt_a, gnt_b});
      end
      reset_n = 1; req_a = 0; last_b = 1;
      @(negedge clock);
      checks++;
      if (mem[9] !== ref_mem[9]) begin
         errs++; $display("FAIL abort_mem: got %h want %h", mem[9], ref_mem[9]);
      end
   endtask

   task automatic test_random();
      int lat; bit who, sw, sr, pe; logic [7:0] rd, sa, sd;
      bit pa, pb, exp;
      logic [7:0] ea;
      pa = 0; pb = 0;
      for (int t = 0; t < 40; t++) begin
         if (!pa && $urandom_range(1) == 1) begin
            pa = 1; we_a = 1'($urandom_range(1));
            addr_a = 8'($urandom_range(15)); wdata_a = 8'($urandom);
         end
         if (!pb && $urandom_range(1) == 1) begin
            pb = 1; we_b = 1'($urandom_range(1));
            addr_b = 8'($urandom_range(15)); wdata_b = 8'($urandom);
         end
         if (!pa && !pb) begin
            pa = 1; we_a = 1'($urandom_range(1));
            addr_a = 8'($urandom_range(15)); wdata_a = 8'($urandom);
         end
         req_a = pa; req_b = pb;
         exp = (pa && pb) ? ~last_b : pb;
         ea = exp ? addr_b : addr_a;
         wait_ack(lat, who, rd, sa, sd, sw, sr, pe);
         checks++;
         if (who !== exp || lat !== 2 || pe || sa !== ea) begin
            errs++; $display("FAIL rnd_%0d: got who=%0d lat=%0d perr=%0d addr=%0d want %0d/2/0/%0d",
                             t, who, lat, pe, sa, exp, ea);
         end
         if ((exp ? we_b : we_a) == 1'b1) begin
            ref_mem[ea] = exp ? wdata_b : wdata_a;
         end else begin
            checks++;
            if (rd !== ref_mem[ea]) begin
               errs++; $display("FAIL rnd_rd_%0d: got %h want %h", t, rd, ref_mem[ea]);
            end
         end
         last_b = exp;
         if (exp) begin pb = 0; req_b = 0; end
         else     begin pa = 0; req_a = 0; end
         @(negedge clock);
      end
      req_a = 0; req_b = 0;
      @(negedge clock);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (mem[i] !== ref_mem[i]) begin
            errs++; $display("FAIL rnd_mem_%0d: got %h want %h", i, mem[i], ref_mem[i]);
         end
      end
   endtask

`ifdef MEM_ARB_LOCK_EN
   task automatic test_lock();
      int lat; bit who, sw, sr, pe; logic [7:0] rd, sa, sd;
      do_reset();
      lock_a = 1;
      req_a = 1; we_a = 0; addr_a = 8'd1;
      req_b = 1; we_b = 0; addr_b = 8'd2;
      for (int i = 0; i < 4; i++) begin
         wait_ack(lat, who, rd, sa, sd, sw, sr, pe);
         checks++;
         if (who !== ((i < 3) ? 1'b0 : 1'b1) || lat < 0) begin
            errs++; $display("FAIL lock_%0d: got who=%0d lat=%0d want %0d",
                             i, who, lat, (i < 3) ? 0 : 1);
         end
         if (i == 2) lock_a = 0;
      end
      req_a = 0; req_b = 0;
      @(negedge clock);
   endtask
`endif

   initial begin
      errs = 0; checks = 0;
      test_reset();
      test_write_read();
      test_tie();
      test_addr_change();
      test_reset_abort();
      test_random();
`ifdef MEM_ARB_LOCK_EN
      test_lock();
`endif
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/mem_dados_arb.md
MEM_DADOS_ARB -- requirements
Module: mem_dados_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have one clock and a synchronous, active-low reset: clock input 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have reset_n input 1, synchronous active-low reset.
REQ-005 SHALL have req_a/req_b input 1, access request from requester A/B; held high until its ack.
REQ-006 SHALL have we_a/we_b input 1, 1 = write, 0 = read.
REQ-007 SHALL have addr_a/addr_b input ADDR_W, access address.
REQ-008 SHALL have wdata_a/wdata_b input DATA_W, write data.
REQ-009 SHALL have gnt_a/gnt_b output 1, requester currently owns the memory.
REQ-010 SHALL have ack_a/ack_b output 1, one-cycle completion pulse.
REQ-011 SHALL have rdata output DATA_W, read data, valid while ack_a or ack_b is high.
REQ-012 SHALL have MemWrite/MemRead output 1, memory strobes.
REQ-013 SHALL have endereco output ADDR_W, memory address.
REQ-014 SHALL have dado_in output DATA_W, memory write data.
REQ-015 SHALL have dado_out input DATA_W, memory read data, combinational from endereco while MemRead is high.

Function
REQ-016 SHALL implement a 3-state FSM: IDLE, SERVE, RESP.
REQ-017 IDLE: if any req is high at the clock edge, SHALL select a winner, register its we/addr/wdata, and go to SERVE; otherwise stay in IDLE.
REQ-018 Arbitration SHALL be round-robin:
- single requester: that requester wins;
- both high: the one not granted last wins;
- last_gnt updates on every grant.
REQ-019 SERVE lasts exactly 1 cycle and SHALL:
- assert gnt_x;
- drive endereco/dado_in from the registered values;
- assert MemWrite=we or MemRead=~we (mutually exclusive);
- capture dado_out into rdata on the exit edge when reading.
REQ-020 RESP lasts exactly 1 cycle and SHALL:
- hold gnt_x;
- pulse ack_x;
- keep rdata stable (unchanged on writes);
- then return to IDLE.
REQ-021 Latency: request sampled at edge k -> SERVE cycle k+1 -> ack in cycle k+2. Throughput: one access per 3 cycles.
REQ-022 Changes on the requester inputs after the capture edge SHALL NOT affect the transaction in flight.
REQ-023 A req dropped before its ack SHALL still complete the captured transaction.
REQ-024 Strobes SHALL be 0 outside SERVE; endereco/dado_in SHALL hold their last values.
REQ-025 At most one gnt and one ack SHALL be high in any cycle.

Reset
REQ-026 reset_n low at an edge SHALL force IDLE and set last_gnt=B (A wins the first tie).
REQ-027 Reset SHALL force the following to 0: gnt_*, ack_*, MemWrite, MemRead, endereco, dado_in, rdata.
REQ-028 Reset during SERVE/RESP SHALL abort the access with no ack; the write edge coinciding with reset SHALL be suppressed.

Configuration
REQ-029 With MEM_ARB_LOCK_EN defined, the block SHALL add lock_a/lock_b inputs (1 bit).
REQ-030 If lock_x is high during RESP and req_x is high in the following IDLE, x SHALL win regardless of round-robin.
REQ-031 Without MEM_ARB_LOCK_EN, the lock ports SHALL be absent and arbitration SHALL be pure round-robin.

Structure
REQ-032 A shared package SHALL hold:
- the FSM state enum (IDLE/SERVE/RESP);
- the requester id encoding (A=0, B=1);
- default ADDR_W/DATA_W constants.
REQ-033 Winner selection SHALL be a sub-module rr_arb2 (req_a, req_b, last_gnt -> win), combinational; the FSM lives in mem_dados_arb.

Verification
REQ-034 Bench SHALL pair the block with Mem_Dados and cover these scenarios:
- Reset pulse, then idle: all outputs 0 and state IDLE for 5 cycles.
- A writes 8'h02 at address 10, then B reads address 10: ack_a two cycles after req; B's rdata=2 with ack_b.
- req_a and req_b both high, continuously: grants alternate A,B,A,B; first grant is A.
- addr_a changed the cycle after capture (10->15): the access still targets address 10.
- reset_n low during SERVE of a write to address 9: no ack; address 9 unchanged.
- MEM_ARB_LOCK_EN defined, lock_a=1, both requesting: A granted 3 consecutive times; after lock_a drops, B granted next.
